hex_key_buffer: RTL and testbench

- Sits directly downstream of the hex keypad scanner and consumes its `Valid`/`Code` outputs plus the raw row lines.
- Converts scanner hits into exactly one key event per physical press, with release debounce and optional auto-repeat.
- Queues events in a small FIFO that the host drains through a valid/ready interface.

---
 rtl/hex_key_buffer_pkg.sv | 19 +
 rtl/hex_key_buffer_fifo.sv | 66 ++++++
 rtl/hex_key_buffer.sv | 178 +++++++++++++++++
 tb/tb_hex_key_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_key_buffer_pkg.sv
// ---------------------------------------------------------------------------
// hex_keypad_pkg
// Purpose : shared types for the hex keypad scanner family (key code width,
//           key code type and the press-tracking FSM state encoding).
// Contents: KEY_W, key_code_t, press_state_t.
// ---------------------------------------------------------------------------
package hex_keypad_pkg;

    localparam int KEY_W = 4;

    typedef logic [KEY_W-1:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        RELEASE
    } press_state_t;

endpackage : hex_keypad_pkg

// File: rtl/hex_key_buffer_fifo.sv
// ---------------------------------------------------------------------------
// key_fifo
// Purpose : small synchronous FIFO for key codes. Push and pop share one
//           clock edge. The parent only issues legal pushes/pops (drop and
//           overflow decisions live upstream).
// Ports   : clock, reset (async, active-high)
//           i_push / i_data  - write one entry
//           i_pop            - remove the head entry
//           o_data           - head entry (0 while empty)
//           o_count          - occupancy 0..DEPTH
//           o_full, o_empty  - occupancy flags
// ---------------------------------------------------------------------------
module key_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // NOTE: storage has no reset; the empty flag masks stale contents, so
    // clearing the array would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_count = r_count;
    // Head reads as 0 while empty so the output is defined out of reset.
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule : key_fifo

// File: rtl/hex_key_buffer.sv
// ---------------------------------------------------------------------------
// hex_key_buffer
// Purpose : turns keypad scanner hits into one key event per physical press
//           (with release debounce), optionally auto-repeats a held key, and
//           queues events for the host in a valid/ready FIFO.
// Build option: define HEX_KEY_BUFFER_REPEAT_EN to compile in auto-repeat.
// Ports   : clock, reset (async, active-high)
//           key_valid, code_in - scanner hit strobe and key code
//           row_in             - synchronised row lines, non-zero = key down
//           out_valid, out_code, out_ready - host drain interface
//           count              - FIFO occupancy
//           overflow           - one-cycle pulse when a push is dropped
// ---------------------------------------------------------------------------
module hex_key_buffer
    import hex_keypad_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int RELEASE_CYCLES = 16,
    parameter int REPEAT_DELAY   = 1024,
    parameter int REPEAT_PERIOD  = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   key_valid,
    input  logic [3:0]             code_in,
    input  logic [3:0]             row_in,
    output logic                   out_valid,
    output logic [3:0]             out_code,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int REL_W = $clog2(RELEASE_CYCLES + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RELEASE_CYCLES < 1 ||
        REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("hex_key_buffer: illegal parameter value");
    end

    press_state_t       r_state;
    logic [REL_W-1:0]   r_release_cnt;
    logic               r_overflow;
    logic               w_push;
    logic               w_push_ok;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    key_code_t          w_push_data;
    key_code_t          w_head;
    logic [$clog2(DEPTH):0] w_count;

`ifdef HEX_KEY_BUFFER_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_repeating;   // first repeat done, now on the period
    key_code_t         r_last_code;
    logic [HOLD_W-1:0] w_hold_next;
    logic [HOLD_W-1:0] w_hold_target;
    logic              w_repeat_hit;

    // The hold counter restarts at every repeat, so it only ever counts up to
    // the delay (first repeat) or the period (later repeats).
    always_comb begin
        w_hold_next   = r_hold_cnt + 1'b1;
        w_hold_target = r_repeating ? HOLD_W'(REPEAT_PERIOD) : HOLD_W'(REPEAT_DELAY);
        w_repeat_hit  = (r_state == HELD) && (row_in != '0) && (w_hold_next == w_hold_target);
    end
`endif

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_push      = (r_state == IDLE) && key_valid;
        w_push_data = code_in;
`ifdef HEX_KEY_BUFFER_REPEAT_EN
        if (w_repeat_hit) begin
            w_push      = 1'b1;
            w_push_data = r_last_code;
        end
`endif
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_pop     = !w_empty && out_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_release_cnt <= '0;
`ifdef HEX_KEY_BUFFER_REPEAT_EN
            r_hold_cnt    <= '0;
            r_repeating   <= 1'b0;
            r_last_code   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (key_valid) begin
                        r_state       <= HELD;
                        r_release_cnt <= '0;
`ifdef HEX_KEY_BUFFER_REPEAT_EN
                        r_last_code   <= code_in;
                        r_hold_cnt    <= '0;
                        r_repeating   <= 1'b0;
`endif
                    end
                end
                HELD: begin
                    if (row_in == '0) begin
                        // The first zero sample already counts toward release.
                        r_release_cnt <= REL_W'(1);
                        r_state       <= (RELEASE_CYCLES == 1) ? IDLE : RELEASE;
                    end else begin
`ifdef HEX_KEY_BUFFER_REPEAT_EN
                        if (w_repeat_hit) begin
                            r_hold_cnt  <= '0;
                            r_repeating <= 1'b1;
                        end else begin
                            r_hold_cnt  <= w_hold_next;
                        end
`endif
                    end
                end
                RELEASE: begin
                    // Hold counter stays frozen here so a bounce resumes the
                    // repeat schedule where it left off.
                    if (row_in != '0) begin
                        r_state       <= HELD;
                        r_release_cnt <= '0;
                    end else if (r_release_cnt == REL_W'(RELEASE_CYCLES - 1)) begin
                        r_state       <= IDLE;
                        r_release_cnt <= '0;
                    end else begin
                        r_release_cnt <= r_release_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && !w_push_ok;
        end
    end

    key_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push_ok),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = !w_empty;
    assign out_code  = w_head;
    assign count     = w_count;
    assign overflow  = r_overflow;

endmodule : hex_key_buffer

// File: tb/tb_hex_key_buffer.sv
// ---------------------------------------------------------------------------
// tb_hex_key_buffer
// Directed bench for hex_key_buffer with DEPTH=4, RELEASE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=4. Inputs change and outputs are sampled on
// the falling clock edge. Expected values that depend on the auto-repeat
// build option follow HEX_KEY_BUFFER_REPEAT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hex_key_buffer;

    localparam int DEPTH = 4;
    localparam int RC    = 4;
`ifdef HEX_KEY_BUFFER_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic       clock;
    logic       reset;
    logic       key_valid;
    logic [3:0] code_in;
    logic [3:0] row_in;
    logic       out_valid;
    logic [3:0] out_code;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;

    int n_total = 0;
    int n_pass  = 0;

    hex_key_buffer #(
        .DEPTH          (DEPTH),
        .RELEASE_CYCLES (RC),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_valid (key_valid),
        .code_in   (code_in),
        .row_in    (row_in),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Single strobe, row held for hold_cycles cycles (strobe cycle included),
    // then RC zero-row cycles so the FSM is back in IDLE afterwards.
    task automatic press(input logic [3:0] code, input logic [3:0] row, input int hold_cycles);
        key_valid = 1'b1;
        code_in   = code;
        row_in    = row;
        tick();
        key_valid = 1'b0;
        repeat (hold_cycles - 1) tick();
        row_in = 4'b0000;
        repeat (RC) tick();
    endtask

    task automatic pop_expect(input string tag, input logic [3:0] exp);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_code"}, out_code, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        code_in   = 4'h0;
        row_in    = 4'h0;
        out_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_valid", out_valid, 1'b0);
        check("rst_code", out_code, 4'h0);
        check("rst_count", count, 3'd0);
        check("rst_ovf", overflow, 1'b0);
        reset = 1'b0;
        tick();

        // 1: single press of 0xA, row held 10 cycles, one rescan ignored
        key_valid = 1'b1; code_in = 4'hA; row_in = 4'b0100;
        tick();
        check("t1_valid_lat", out_valid, 1'b1);
        check("t1_code", out_code, 4'hA);
        check("t1_count", count, 3'd1);
        key_valid = 1'b0;
        tick();
        key_valid = 1'b1; code_in = 4'h5;
        tick();
        key_valid = 1'b0;
        check("t1_rescan_ignored", count, 3'd1);
        repeat (7) tick();
        check("t1_held_count", count, 3'(1 + REP));
        row_in = 4'b0000;
        repeat (RC) tick();
        check("t1_after_release", count, 3'(1 + REP));
        for (int i = 0; i < 1 + REP; i++) pop_expect("t1_drain", 4'hA);
        check("t1_empty", out_valid, 1'b0);

        // 2: bounce shorter than release, strobe during bounce is ignored
        key_valid = 1'b1; code_in = 4'h9; row_in = 4'b0001;
        tick();
        key_valid = 1'b0;
        row_in = 4'b0000;
        repeat (2) tick();
        row_in = 4'b0001; key_valid = 1'b1; code_in = 4'h3;
        tick();
        key_valid = 1'b0;
        check("t2_bounce_ignored", count, 3'd1);
        tick();
        row_in = 4'b0000;
        repeat (3) tick();
        key_valid = 1'b1; code_in = 4'h3;   // lands on the edge completing release
        tick();
        key_valid = 1'b0;
        check("t2_release_edge_ignored", count, 3'd1);
        press(4'h3, 4'b0010, 2);
        check("t2_new_press", count, 3'd2);
        pop_expect("t2_pop0", 4'h9);
        pop_expect("t2_pop1", 4'h3);
        check("t2_empty", count, 3'd0);

        // 3: fill to DEPTH, fifth press overflows
        for (int c = 1; c <= 4; c++) press(4'(c), 4'b0001, 2);
        check("t3_full_count", count, 3'd4);
        check("t3_no_ovf", overflow, 1'b0);
        key_valid = 1'b1; code_in = 4'h5; row_in = 4'b0001;
        tick();
        key_valid = 1'b0;
        check("t3_ovf_pulse", overflow, 1'b1);
        check("t3_count_held", count, 3'd4);
        tick();
        check("t3_ovf_cleared", overflow, 1'b0);
        check("t3_head", out_code, 4'h1);
        row_in = 4'b0000;
        repeat (RC) tick();

        // 4: full FIFO, push and pop together
        key_valid = 1'b1; code_in = 4'h7; row_in = 4'b0001; out_ready = 1'b1;
        tick();
        key_valid = 1'b0; out_ready = 1'b0;
        check("t4_count", count, 3'd4);
        check("t4_no_ovf", overflow, 1'b0);
        tick();
        row_in = 4'b0000;
        repeat (RC) tick();
        pop_expect("t4_pop2", 4'h2);
        pop_expect("t4_pop3", 4'h3);
        pop_expect("t4_pop4", 4'h4);
        pop_expect("t4_pop7", 4'h7);
        check("t4_empty", out_valid, 1'b0);

        // 5: hold 0xF for 20 cycles
        key_valid = 1'b1; code_in = 4'hF; row_in = 4'b1000;
        tick();
        key_valid = 1'b0;
        repeat (8) tick();
        check("t5_first_repeat", count, 3'(1 + REP));
        repeat (11) tick();
        row_in = 4'b0000;
        repeat (RC) tick();
        check("t5_total", count, 3'(1 + 3 * REP));
        check("t5_no_ovf", overflow, 1'b0);
        for (int i = 0; i < 1 + 3 * REP; i++) pop_expect("t5_drain", 4'hF);
        check("t5_empty", count, 3'd0);

        // 6: reset while HELD with three entries
        press(4'h1, 4'b0001, 2);
        press(4'h2, 4'b0001, 2);
        key_valid = 1'b1; code_in = 4'h6; row_in = 4'b0100;
        tick();
        key_valid = 1'b0;
        tick();
        check("t6_pre_count", count, 3'd3);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_count", count, 3'd0);
        check("t6_rst_valid", out_valid, 1'b0);
        check("t6_rst_code", out_code, 4'h0);
        tick();
        reset = 1'b0;
        row_in = 4'b0000;
        tick();
        key_valid = 1'b1; code_in = 4'hC; row_in = 4'b0001;
        tick();
        key_valid = 1'b0;
        check("t6_post_count", count, 3'd1);
        check("t6_post_code", out_code, 4'hC);
        row_in = 4'b0000;
        repeat (RC) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_hex_key_buffer
